// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential Vedic 8x8 multiplier.
// The state enum and the half-width split are used by the top and by the 4x4 core.
package vedic_pkg;

  localparam int unsigned OpWDefault  = 8;
  localparam int unsigned AddWDefault = 12;
  localparam int unsigned HalfW       = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAdd1 = 3'd1,
    StAdd2 = 3'd2,
    StAdd3 = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/vedic_mul_4x4.sv
// Combinational 4x4 unsigned multiplier built column by column (vertical and crosswise).
// Each column sums its bit products plus the carry from the previous column.
module vedic_mul_4x4
  import vedic_pkg::*;
(
  input  logic [HalfW-1:0]   x_i,
  input  logic [HalfW-1:0]   y_i,
  output logic [2*HalfW-1:0] p_o
);

  logic [3:0]       col;
  logic [3:0]       carry;
  logic [HalfW-1:0] xs;
  logic [HalfW-1:0] ys;

  always_comb begin
    p_o   = '0;
    col   = '0;
    carry = '0;
    xs    = '0;
    ys    = '0;
    for (int k = 0; k < 2 * HalfW - 1; k++) begin
      col = carry;
      for (int i = 0; i < HalfW; i++) begin
        if ((k - i) >= 0 && (k - i) < HalfW) begin
          xs  = x_i >> i;
          ys  = y_i >> (k - i);
          col = col + {3'b000, xs[0] & ys[0]};
        end
      end
      p_o   = p_o | ((2 * HalfW)'(col[0]) << k);
      carry = col >> 1;
    end
    // The full product fits in 8 bits, so only one carry bit survives the last column.
    p_o = p_o | ((2 * HalfW)'(carry[0]) << (2 * HalfW - 1));
  end

endmodule

// File: rtl/vedic8_seq_ctrl.sv
// Sequential 8x8 multiplier: four 4x4 partial products combined over three cycles
// through a single shared adder, with a one-cycle done pulse.
module vedic8_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int unsigned OP_W  = OpWDefault,
  parameter int unsigned ADD_W = AddWDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                busy,
  output logic                done,
  output logic [2*OP_W-1:0]   product
);

  state_e state_q, state_d;

  logic [OP_W-1:0]    a_q, a_d;
  logic [OP_W-1:0]    b_q, b_d;
  logic [ADD_W-1:0]   acc_q, acc_d;
  logic [2*OP_W-1:0]  prod_q, prod_d;

  logic [ADD_W-1:0]   add_a, add_b, add_sum;
  logic [2*HalfW-1:0] q0, q1, q2, q3;

  vedic_mul_4x4 u_mul_q0 (
    .x_i(a_q[HalfW-1:0]),
    .y_i(b_q[HalfW-1:0]),
    .p_o(q0)
  );

  vedic_mul_4x4 u_mul_q1 (
    .x_i(a_q[2*HalfW-1:HalfW]),
    .y_i(b_q[HalfW-1:0]),
    .p_o(q1)
  );

  vedic_mul_4x4 u_mul_q2 (
    .x_i(a_q[HalfW-1:0]),
    .y_i(b_q[2*HalfW-1:HalfW]),
    .p_o(q2)
  );

  vedic_mul_4x4 u_mul_q3 (
    .x_i(a_q[2*HalfW-1:HalfW]),
    .y_i(b_q[2*HalfW-1:HalfW]),
    .p_o(q3)
  );

  // The one adder in the datapath; its operands are steered by the current state.
  always_comb begin
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      StAdd1: begin
        add_a = ADD_W'(q1);
        add_b = ADD_W'(q2);
      end
      StAdd2: begin
        add_a = acc_q;
        add_b = ADD_W'(q0[2*HalfW-1:HalfW]);
      end
      StAdd3: begin
        add_a = ADD_W'(q3);
        add_b = acc_q >> HalfW;
      end
      default: ;
    endcase
  end

  assign add_sum = add_a + add_b;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = StAdd1;
        end
      end
      StAdd1: begin
        acc_d   = add_sum;
        state_d = StAdd2;
      end
      StAdd2: begin
        acc_d                        = add_sum;
        prod_d[HalfW-1:0]            = q0[HalfW-1:0];
        prod_d[2*HalfW-1:HalfW]      = add_sum[HalfW-1:0];
        state_d                      = StAdd3;
      end
      StAdd3: begin
        // Upper byte cannot carry out: at most 225 + 29.
        prod_d[2*OP_W-1:OP_W] = add_sum[OP_W-1:0];
        state_d               = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign product = prod_q;

endmodule

// File: tb/tb_vedic8_seq_ctrl.sv
// Self-checking bench for vedic8_seq_ctrl: directed corner cases plus random operands
// compared against plain a*b, with timing, busy and hold behaviour checked per operation.
module tb_vedic8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned last_done_cyc;
  logic [15:0] exp_prod;

  vedic8_seq_ctrl #(
    .OP_W (8),
    .ADD_W(12)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One multiply: start in an idle cycle, scramble a/b once accepted, optionally
  // re-pulse start during ADD2, then wait (bounded) for done and check everything.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input bit poke);
    int          n;
    bit          seen;
    logic [15:0] prev;
    logic [15:0] want;
    prev = exp_prod;
    want = ta * tb;
    @(negedge clk);
    check_eq("idle_done", {31'd0, done}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    start = 1'b1;
    a     = ta;
    b     = tb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    seen  = 1'b0;
    n     = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      check_eq("busy", {31'd0, busy}, 32'd1);
      if (n == 1) check_eq("hold_prev", {16'd0, product}, {16'd0, prev});
      if (done) begin
        seen          = 1'b1;
        last_done_cyc = cyc;
      end
      if (poke && n == 2) begin
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
      end
      if (n == 3) start = 1'b0;
    end
    start = 1'b0;
    check_eq("latency", n, 4);
    check_eq("product", {16'd0, product}, {16'd0, want});
    exp_prod = want;
  endtask

  initial begin
    int unsigned t_first;
    n_cmp    = 0;
    n_err    = 0;
    exp_prod = 16'h0000;
    last_done_cyc = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_product", {16'd0, product}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op(8'h12, 8'h34, 1'b0);
    check_eq("dir_0x12x0x34", {16'd0, product}, 32'h03A8);
    run_op(8'hFF, 8'hFF, 1'b0);
    check_eq("dir_max", {16'd0, product}, 32'hFE01);

    run_op(8'h00, 8'hAB, 1'b0);
    t_first = last_done_cyc;
    run_op(8'hA5, 8'h5A, 1'b0);
    check_eq("dir_0xA5x0x5A", {16'd0, product}, 32'h3A02);
    check_eq("b2b_gap", last_done_cyc - t_first, 5);

    run_op(8'h37, 8'hC9, 1'b1);

    // Abort mid-operation during ADD2.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h9C;
    b     = 8'h6E;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_product", {16'd0, product}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_prod = 16'h0000;
    run_op(8'h9C, 8'h6E, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
